output_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the CPU's shared 10-bit output port. Up to four internal requesters compete to place a word on the port.
- The block grants one requester at a time and latches its word. It then drives OE and the word toward the output buffer and holds them until the external consumer accepts.
- After each transfer it inserts a programmable bus-turnaround gap. A stalled consumer is aborted by a watchdog timeout.

---
 rtl/output_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_output_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/output_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared 10-bit output port.
// It grants one requester at a time and drives that word until it is accepted, then holds a turnaround gap.
module output_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TURN_CYCLES = 1,
    parameter int TIMEOUT     = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [10*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   grant,
    output logic               oe,
    output logic [9:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               timeout_err,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] TURN_LAST  = (TURN_CYCLES > 0) ? 3'(TURN_CYCLES - 1) : 3'd0;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] winner;
    logic [1:0] win_idx;
    logic       win_found;
    logic [1:0] next_ptr;
    logic [7:0] timer;
    logic [2:0] turn_cnt;
    int         idx;

    // First set request at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = 2'(idx);
            end
        end
    end

    assign next_ptr  = (winner == 2'(N_REQ - 1)) ? 2'd0 : winner + 2'd1;
    assign out_valid = oe;
    assign state_dbg = state;

    // Handshake: out_valid (== oe) holds a stable word through DRIVE; the word is
    // consumed at the first rising edge where out_ready is high while out_valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= 2'd0;
            winner      <= 2'd0;
            timer       <= 8'd0;
            turn_cnt    <= 3'd0;
            grant       <= '0;
            oe          <= 1'b0;
            out_data    <= 10'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant       <= '0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        winner         <= win_idx;
                        grant[win_idx] <= 1'b1;
                        out_data       <= req_data[10*int'(win_idx) +: 10];
                        oe             <= 1'b1;
                        busy           <= 1'b1;
                        timer          <= 8'd0;
                        state          <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    // A late out_ready on the watchdog edge still counts as a completion.
                    if (out_ready || timer == TIMER_LAST) begin
                        timeout_err <= !out_ready;
                        ptr         <= next_ptr;
                        oe          <= 1'b0;
                        out_data    <= 10'd0;
                        if (TURN_CYCLES == 0) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_TURN;
                            turn_cnt <= TURN_LAST;
                        end
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_TURN: begin
                    if (turn_cnt == 3'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        turn_cnt <= turn_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    oe    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_bus_arbiter.sv
// Directed bench for output_bus_arbiter: a default instance plus a two-requester, zero-turnaround instance.
module tb_output_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [39:0] req_data;
    logic [3:0]  grant;
    logic        oe;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    logic [1:0]  req2;
    logic [19:0] req_data2;
    logic [1:0]  grant2;
    logic        oe2;
    logic [9:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic        busy2;
    logic        timeout_err2;
    logic [1:0]  state_dbg2;

    int checks = 0;
    int errors = 0;

    output_bus_arbiter #(.N_REQ(4), .TURN_CYCLES(1), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
        .oe(oe), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
    );

    output_bus_arbiter #(.N_REQ(2), .TURN_CYCLES(0), .TIMEOUT(15)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .req_data(req_data2), .grant(grant2),
        .oe(oe2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .busy(busy2), .timeout_err(timeout_err2), .state_dbg(state_dbg2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [3:0] g, input logic o,
                           input logic [9:0] d, input logic b, input logic e);
        chk({tag, ".grant"}, 16'(grant), 16'(g));
        chk({tag, ".oe"}, 16'(oe), 16'(o));
        chk({tag, ".valid"}, 16'(out_valid), 16'(o));
        chk({tag, ".data"}, 16'(out_data), 16'(d));
        chk({tag, ".busy"}, 16'(busy), 16'(b));
        chk({tag, ".err"}, 16'(timeout_err), 16'(e));
    endtask

    initial begin
        logic [9:0] rr_word [4];
        rr_word[0] = 10'h101;
        rr_word[1] = 10'h202;
        rr_word[2] = 10'h303;
        rr_word[3] = 10'h0C4;

        rst = 1'b1;
        req = '0;
        req_data = '0;
        out_ready = 1'b0;
        req2 = '0;
        req_data2 = '0;
        out_ready2 = 1'b1;
        tick();
        tick();
        chk_bus("reset", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);
        chk("reset.state", 16'(state_dbg), 16'd0);
        rst = 1'b0;
        tick();
        chk_bus("idle_no_req", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Single transfer from requester 2 with the consumer always ready
        req = 4'b0100;
        req_data[29:20] = 10'h15A;
        out_ready = 1'b1;
        tick();
        chk_bus("single.drive", 4'b0100, 1'b1, 10'h15A, 1'b1, 1'b0);
        chk("single.state", 16'(state_dbg), 16'd1);
        req = 4'b0000;
        tick();
        chk_bus("single.turn", 4'b0000, 1'b0, 10'h000, 1'b1, 1'b0);
        chk("single.turn_state", 16'(state_dbg), 16'd2);
        tick();
        chk_bus("single.idle", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Reset in the middle of a stalled DRIVE (pointer is 3, so requester 0 wins)
        req = 4'b0001;
        req_data[9:0] = 10'h2A5;
        out_ready = 1'b0;
        tick();
        chk_bus("rst_mid.drive", 4'b0001, 1'b1, 10'h2A5, 1'b1, 1'b0);
        tick();
        req = 4'b0000;
        rst = 1'b1;
        #1;
        chk_bus("rst_mid.async", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        chk_bus("rst_mid.no_stale", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Round robin with all requesters held high
        req_data = {rr_word[3], rr_word[2], rr_word[1], rr_word[0]};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr%0d.grant", k), 16'(grant), 16'(4'b0001 << (k % 4)));
            chk($sformatf("rr%0d.data", k), 16'(out_data), 16'(rr_word[k % 4]));
            if (k < 4) begin
                tick();
                tick();
            end
        end
        req = 4'b0000;
        tick();
        tick();
        chk_bus("rr.idle", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Backpressure: pointer is 1, word 3FF held for six DRIVE cycles
        req = 4'b0010;
        req_data[19:10] = 10'h3FF;
        out_ready = 1'b0;
        tick();
        chk("bp.grant", 16'(grant), 16'(4'b0010));
        req = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("bp%0d.oe", i), 16'(oe), 16'd1);
            chk($sformatf("bp%0d.data", i), 16'(out_data), 16'h3FF);
            chk($sformatf("bp%0d.err", i), 16'(timeout_err), 16'd0);
            out_ready = (i == 6);
            tick();
        end
        chk_bus("bp.turn", 4'b0000, 1'b0, 10'h000, 1'b1, 1'b0);
        tick();

        // Timeout: requester 2 stalls 15 cycles, then requester 3 must be next
        req_data[29:20] = 10'h155;
        req_data[39:30] = 10'h2AA;
        req = 4'b1100;
        out_ready = 1'b0;
        tick();
        chk("to.grant", 16'(grant), 16'(4'b0100));
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("to%0d.oe", i), 16'(oe), 16'd1);
            chk($sformatf("to%0d.err", i), 16'(timeout_err), 16'd0);
            tick();
        end
        chk_bus("to.abort", 4'b0000, 1'b0, 10'h000, 1'b1, 1'b1);
        tick();
        chk_bus("to.idle", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);
        tick();
        chk_bus("to.next", 4'b1000, 1'b1, 10'h2AA, 1'b1, 1'b0);

        // Ready arriving on the watchdog edge completes the transfer
        req = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("late%0d.oe", i), 16'(oe), 16'd1);
            out_ready = (i == 15);
            tick();
        end
        chk_bus("late.turn", 4'b0000, 1'b0, 10'h000, 1'b1, 1'b0);
        tick();
        chk_bus("late.idle", 4'b0000, 1'b0, 10'h000, 1'b0, 1'b0);

        // Zero turnaround, two requesters: one transfer every two cycles
        req_data2 = {10'h0AB, 10'h0CD};
        req2 = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("z%0d.grant", k), 16'(grant2), 16'((k % 2 == 0) ? 2'b01 : 2'b10));
            chk($sformatf("z%0d.data", k), 16'(out_data2), 16'((k % 2 == 0) ? 10'h0CD : 10'h0AB));
            chk($sformatf("z%0d.oe", k), 16'(oe2), 16'd1);
            tick();
            chk($sformatf("z%0d.gap_oe", k), 16'(oe2), 16'd0);
            chk($sformatf("z%0d.gap_busy", k), 16'(busy2), 16'd0);
        end
        chk("z.err", 16'(timeout_err2), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
